// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
//   Shared definitions for the vending-machine controller:
//     - state_t      : FSM state encoding (IDLE / COLLECT / VEND / CHANGE)
//     - DEF_*        : default price, coin denominations and widths
//     - max4()       : elaboration helper used to size-check the credit path
// ---------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    localparam int DEF_PRICE    = 6;
    localparam int DEF_DEN0     = 1;
    localparam int DEF_DEN1     = 2;
    localparam int DEF_DEN2     = 5;
    localparam int DEF_DEN3     = 10;
    localparam int DEF_CREDIT_W = 5;
    localparam int DEF_CNT_W    = 16;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vend_sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   asynchronous active-high reset, clears the count
//     inc   in   count up by one this cycle
//     cnt   out  current count (CNT_W bits)
// ---------------------------------------------------------------------------
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vend_fsm.sv
// ---------------------------------------------------------------------------
// vend_fsm
//   Vending-machine controller. Accepts coins of four denominations, vends
//   one item when credit reaches PRICE, and hands change or a cancel refund
//   to the changer through a valid/ready port. Counts items sold (saturating).
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     coin_vld  in   coin present this cycle
//     coin_sel  in   [1:0] denomination index of the coin
//     cancel    in   refund current credit (ignored in VEND/CHANGE)
//     coin_rdy  out  coins are accepted this cycle (IDLE/COLLECT)
//     coin_rej  out  1-cycle pulse: a coin was offered while coin_rdy=0
//     vend      out  1-cycle pulse: dispense one item
//     chg_vld   out  change/refund amount valid
//     chg_amt   out  [CREDIT_W-1:0] change/refund amount, 0 when !chg_vld
//     chg_rdy   in   changer accepts chg_amt
//     credit    out  [CREDIT_W-1:0] current credit
//     sold_cnt  out  [CNT_W-1:0] items vended, saturating
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no credit, waiting for coins
//   COLLECT  | 0 < credit < PRICE, waiting for more coins or cancel
//   VEND     | single cycle: dispense, deduct PRICE, bump sold counter
//   CHANGE   | present credit on chg_amt until the changer takes it
// ---------------------------------------------------------------------------
module vend_fsm
    import vend_pkg::*;
#(
    parameter int PRICE    = DEF_PRICE,
    parameter int DEN0     = DEF_DEN0,
    parameter int DEN1     = DEF_DEN1,
    parameter int DEN2     = DEF_DEN2,
    parameter int DEN3     = DEF_DEN3,
    parameter int CREDIT_W = DEF_CREDIT_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_vld,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    output logic                coin_rdy,
    output logic                coin_rej,
    output logic                vend,
    output logic                chg_vld,
    output logic [CREDIT_W-1:0] chg_amt,
    input  logic                chg_rdy,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    sold_cnt
);

    // Largest credit ever held is PRICE-1 plus the biggest coin; the credit
    // register must hold that without wrapping.
    localparam int MAX_DEN    = max4(DEN0, DEN1, DEN2, DEN3);
    localparam int MAX_CREDIT = PRICE - 1 + MAX_DEN;

    if (PRICE < 1) begin : g_bad_price
        $error("vend_fsm: PRICE must be >= 1");
    end
    if (MAX_CREDIT > (2 ** CREDIT_W) - 1) begin : g_bad_width
        $error("vend_fsm: CREDIT_W too narrow for PRICE-1+max(DEN)");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state;
    state_t              state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic [CREDIT_W-1:0] remainder;
    logic                coin_take;
    logic                vend_cyc;

    // Denomination mux
    always_comb begin
        coin_val = '0;
        unique case (coin_sel)
            2'd0: coin_val = CREDIT_W'(DEN0);
            2'd1: coin_val = CREDIT_W'(DEN1);
            2'd2: coin_val = CREDIT_W'(DEN2);
            2'd3: coin_val = CREDIT_W'(DEN3);
            default: coin_val = '0;
        endcase
    end

    assign coin_take = coin_vld & coin_rdy;
    assign sum       = credit + (coin_take ? coin_val : '0);
    assign remainder = credit - PRICE_C;

    // State and credit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            credit <= '0;
        end else begin
            state  <= state_nxt;
            credit <= credit_nxt;
        end
    end

    // coin_rej reports a refused coin one cycle after it was offered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_rej <= 1'b0;
        end else begin
            coin_rej <= coin_vld & ~coin_rdy;
        end
    end

    // Next state / credit
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        unique case (state)
            ST_IDLE, ST_COLLECT: begin
                credit_nxt = sum;
                // Cancel is checked before the price compare so that a coin
                // reaching PRICE together with cancel is refunded, not sold.
                if (cancel && (sum != '0)) begin
                    state_nxt = ST_CHANGE;
                end else if (sum >= PRICE_C) begin
                    state_nxt = ST_VEND;
                end else if (sum != '0) begin
                    state_nxt = ST_COLLECT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_VEND: begin
                credit_nxt = remainder;
                state_nxt  = (remainder != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (chg_rdy) begin
                    credit_nxt = '0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                credit_nxt = '0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        coin_rdy = 1'b0;
        vend_cyc = 1'b0;
        chg_vld  = 1'b0;
        chg_amt  = '0;
        unique case (state)
            ST_IDLE, ST_COLLECT: coin_rdy = 1'b1;
            ST_VEND:             vend_cyc = 1'b1;
            ST_CHANGE: begin
                chg_vld = 1'b1;
                chg_amt = credit;
            end
            default: ;
        endcase
    end

    assign vend = vend_cyc;

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sold_cnt (
        .clk (clk),
        .rst (rst),
        .inc (vend_cyc),
        .cnt (sold_cnt)
    );

endmodule

// File: tb/tb_vend_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_fsm
//   Directed per-cycle vector table for the named scenarios, a hand-written
//   async-reset sequence, then randomized traffic compared against a
//   transaction-level model (credit, "owed change" and "item due" bookkeeping).
//   A second instance with a 2-bit sold counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_vend_fsm;

    localparam int PRICE = 6;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_vld = 1'b0;
    logic [1:0]    coin_sel = 2'd0;
    logic          cancel = 1'b0;
    logic          chg_rdy = 1'b0;

    logic          coin_rdy, coin_rej, vend, chg_vld;
    logic [CW-1:0] chg_amt, credit;
    logic [15:0]   sold_cnt;

    logic          s_coin_rdy, s_coin_rej, s_vend, s_chg_vld;
    logic [CW-1:0] s_chg_amt, s_credit;
    logic [1:0]    s_sold_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_fsm dut (
        .clk(clk), .rst(rst), .coin_vld(coin_vld), .coin_sel(coin_sel),
        .cancel(cancel), .coin_rdy(coin_rdy), .coin_rej(coin_rej),
        .vend(vend), .chg_vld(chg_vld), .chg_amt(chg_amt), .chg_rdy(chg_rdy),
        .credit(credit), .sold_cnt(sold_cnt)
    );

    vend_fsm #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .coin_vld(coin_vld), .coin_sel(coin_sel),
        .cancel(cancel), .coin_rdy(s_coin_rdy), .coin_rej(s_coin_rej),
        .vend(s_vend), .chg_vld(s_chg_vld), .chg_amt(s_chg_amt), .chg_rdy(chg_rdy),
        .credit(s_credit), .sold_cnt(s_sold_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       rst;
        bit       cv;
        bit [1:0] sel;
        bit       can;
        bit       crdy;
        bit       e_rdy;
        bit       e_rej;
        bit       e_vend;
        bit       e_cvld;
        int       e_amt;
        int       e_credit;
        int       e_sold;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit r, input bit cv, input bit [1:0] sel, input bit can,
                       input bit crdy, input bit e_rdy, input bit e_rej, input bit e_vend,
                       input bit e_cvld, input int e_amt, input int e_credit, input int e_sold);
        vec_t v;
        v.rst = r; v.cv = cv; v.sel = sel; v.can = can; v.crdy = crdy;
        v.e_rdy = e_rdy; v.e_rej = e_rej; v.e_vend = e_vend; v.e_cvld = e_cvld;
        v.e_amt = e_amt; v.e_credit = e_credit; v.e_sold = e_sold;
        tv.push_back(v);
    endtask

    // Transaction-level reference: credit held, an item due next cycle,
    // change owed to the changer, a refused coin to report, items sold.
    int den[4] = '{1, 2, 5, 10};
    int m_credit, m_sold;
    bit m_item_due, m_owing, m_rej;

    task automatic model_reset();
        m_credit = 0; m_sold = 0; m_item_due = 0; m_owing = 0; m_rej = 0;
    endtask

    task automatic model_step(input bit cv, input int sel, input bit can, input bit crdy);
        bit busy;
        int total;
        busy  = m_item_due || m_owing;
        m_rej = cv && busy;
        if (m_item_due) begin
            m_item_due = 0;
            m_sold++;
            m_credit = m_credit - PRICE;
            m_owing  = (m_credit > 0);
        end else if (m_owing) begin
            if (crdy) begin
                m_owing  = 0;
                m_credit = 0;
            end
        end else begin
            total = m_credit + (cv ? den[sel] : 0);
            m_credit = total;
            if (can && total > 0) m_owing = 1;
            else if (total >= PRICE) m_item_due = 1;
        end
    endtask

    initial begin
        // ---- directed vector table -----------------------------------------
        //   rst cv sel can crdy | rdy rej vend cvld amt credit sold
        add(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);   // reset state
        add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);   // 1: coin 1
        add(0, 1, 2, 0, 0,   1, 0, 0, 0, 0, 1, 0);   //    coin 5
        add(0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 6, 0);   //    vend
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);   //    idle, no change
        add(0, 1, 2, 0, 0,   1, 0, 0, 0, 0, 0, 1);   // 2: coin 5
        add(0, 1, 2, 0, 0,   1, 0, 0, 0, 0, 5, 1);   //    coin 5
        add(0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 10, 1);  //    vend
        add(0, 0, 0, 0, 0,   0, 0, 0, 1, 4, 4, 2);   //    change held
        add(0, 0, 0, 0, 0,   0, 0, 0, 1, 4, 4, 2);
        add(0, 0, 0, 0, 0,   0, 0, 0, 1, 4, 4, 2);
        add(0, 0, 0, 0, 1,   0, 0, 0, 1, 4, 4, 2);   //    accepted
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2);   //    idle
        add(0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 2);   // 3: coin 2
        add(0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 2, 2);   //    cancel
        add(0, 0, 0, 0, 1,   0, 0, 0, 1, 2, 2, 2);   //    refund 2
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2);
        add(0, 1, 3, 0, 0,   1, 0, 0, 0, 0, 0, 2);   // 4: coin 10
        add(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 10, 2);  //    coin 1 during vend
        add(0, 0, 0, 0, 0,   0, 1, 0, 1, 4, 4, 3);   //    rej pulse, change 4
        add(0, 0, 0, 0, 1,   0, 0, 0, 1, 4, 4, 3);
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 3);
        add(0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 3);   // 5: coin 2
        add(0, 1, 2, 1, 0,   1, 0, 0, 0, 0, 2, 3);   //    coin 5 + cancel
        add(0, 0, 0, 0, 0,   0, 0, 0, 1, 7, 7, 3);   //    refund 7, no vend
        add(0, 0, 0, 0, 1,   0, 0, 0, 1, 7, 7, 3);
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 3);
        add(0, 1, 3, 0, 0,   1, 0, 0, 0, 0, 0, 3);   // 6: coin 10
        add(0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 10, 3);
        add(0, 0, 0, 0, 0,   0, 0, 0, 1, 4, 4, 4);   //    in CHANGE
        add(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);   //    reset
        add(0, 1, 2, 0, 0,   1, 0, 0, 0, 0, 0, 0);   //    coin 5
        add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 5, 0);   //    coin 1
        add(0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 6, 0);   //    vend, cancel ignored
        add(0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 1);   //    cancel at zero credit
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);   //    stays idle

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; coin_vld = tv[i].cv; coin_sel = tv[i].sel;
            cancel = tv[i].can; chg_rdy = tv[i].crdy;
            #1;
            chk($sformatf("v%0d coin_rdy", i), 32'(coin_rdy), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d coin_rej", i), 32'(coin_rej), 32'(tv[i].e_rej));
            chk($sformatf("v%0d vend", i),     32'(vend),     32'(tv[i].e_vend));
            chk($sformatf("v%0d chg_vld", i),  32'(chg_vld),  32'(tv[i].e_cvld));
            chk($sformatf("v%0d chg_amt", i),  32'(chg_amt),  tv[i].e_amt);
            chk($sformatf("v%0d credit", i),   32'(credit),   tv[i].e_credit);
            chk($sformatf("v%0d sold_cnt", i), 32'(sold_cnt), tv[i].e_sold);
        end

        // ---- async reset asserted between clock edges during CHANGE --------
        @(negedge clk); rst = 0; coin_vld = 1; coin_sel = 2'd3; cancel = 0; chg_rdy = 0;
        @(negedge clk); coin_vld = 0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("seq chg_vld before rst", 32'(chg_vld), 32'd1);
        chk("seq chg_amt before rst", 32'(chg_amt), 32'd4);
        #2 rst = 1;
        #1;
        chk("seq async chg_vld", 32'(chg_vld), 32'd0);
        chk("seq async credit",  32'(credit),  32'd0);
        chk("seq async sold",    32'(sold_cnt), 32'd0);
        chk("seq async coin_rdy", 32'(coin_rdy), 32'd1);

        // ---- randomized traffic against the reference model ----------------
        @(negedge clk);
        rst = 1; #1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit r, cv, can, crdy;
            int sel;
            int s_exp;
            @(negedge clk);
            r    = ($urandom_range(0, 249) == 0);
            cv   = ($urandom_range(0, 1) == 1);
            sel  = $urandom_range(0, 3);
            can  = ($urandom_range(0, 9) == 0);
            crdy = ($urandom_range(0, 2) != 0);
            rst = r; coin_vld = cv; coin_sel = 2'(sel); cancel = can; chg_rdy = crdy;
            #1;
            if (r) model_reset();
            chk("rnd coin_rdy", 32'(coin_rdy), 32'(!(m_item_due || m_owing)));
            chk("rnd coin_rej", 32'(coin_rej), 32'(m_rej));
            chk("rnd vend",     32'(vend),     32'(m_item_due));
            chk("rnd chg_vld",  32'(chg_vld),  32'(m_owing));
            chk("rnd chg_amt",  32'(chg_amt),  m_owing ? m_credit : 0);
            chk("rnd credit",   32'(credit),   m_credit);
            chk("rnd sold_cnt", 32'(sold_cnt), m_sold);
            s_exp = (m_sold > 3) ? 3 : m_sold;
            chk("rnd sat sold_cnt", 32'(s_sold_cnt), s_exp);
            if (!r) model_step(cv, sel, can, crdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
